// File: rtl/capt_issuer_pkg.sv
// rtl/capt_issuer_pkg.sv - shared op encodings and issuer FSM state type
// Op encodings are shared with the downstream capture counter.
package capt_issuer_pkg;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_INC = 2'b01;
   localparam logic [1:0] OP_DEC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_DRAIN_END = 2'd2
   } state_t;

endpackage

// File: rtl/capt_issuer_op_fifo.sv
// rtl/capt_issuer_op_fifo.sv - DEPTH x 2-bit op queue with occupancy count
// Ports:
//   clock, rst_n      : clock and asynchronous active-low reset
//   push, push_data   : enqueue strobe and op; dropped while q_full
//   pop               : dequeue strobe; caller only pops a non-empty queue
//   head              : op at the front of the queue
//   q_full, q_empty   : combinational from the occupancy count
//   count             : occupancy, 0..DEPTH
module op_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          push,
   input  logic [1:0]    push_data,
   input  logic          pop,
   output logic [1:0]    head,
   output logic          q_full,
   output logic          q_empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          push_ok;
   logic          pop_ok;

   assign q_full  = (count == FULL_CNT);
   assign q_empty = (count == '0);
   assign head    = mem[rptr];

   // Full check uses the occupancy before any same-cycle pop.
   assign push_ok = push && !q_full;
   assign pop_ok  = pop && !q_empty;

   // Storage needs no reset: entries are only read once counted as valid.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wptr] <= push_data;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + PTR_ONE;
         if (pop_ok)  rptr <= rptr + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/capt_issuer.sv
// rtl/capt_issuer.sv - buffers host ops and issues them as capture strobes
// Ports:
//   clock, rst_n      : clock and asynchronous active-low reset
//   wr_en, wr_op      : host push into the op queue (any FSM state)
//   start             : begin a drain; only honoured in IDLE
//   full              : downstream full; stalls issuing while high
//   op, capture       : registered strobe to the capture counter (op=00 when idle)
//   q_full, q_empty   : queue occupancy flags
//   busy, done        : FSM not idle / one-cycle drain-complete pulse
//   issued            : ops issued since the last accepted start
module capt_issuer
   import capt_issuer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int CW    = 8
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [1:0]    wr_op,
   input  logic          start,
   input  logic          full,
   output logic [1:0]    op,
   output logic          capture,
   output logic          q_full,
   output logic          q_empty,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] issued
);

   state_t        state;
   state_t        state_nxt;
   logic          pop;
   logic          has_entry;
   logic          start_ok;
   logic [1:0]    head;
   logic [AW:0]   occupancy;

   op_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clock     (clock),
      .rst_n     (rst_n),
      .push      (wr_en),
      .push_data (wr_op),
      .pop       (pop),
      .head      (head),
      .q_full    (q_full),
      .q_empty   (q_empty),
      .count     (occupancy)
   );

   assign has_entry = (occupancy != '0);

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (start) state_nxt = ST_ISSUE;
         // An empty queue ends the drain even if downstream is full.
         ST_ISSUE:     if (!has_entry) state_nxt = ST_DRAIN_END;
         ST_DRAIN_END: state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pop      = (state == ST_ISSUE) && has_entry && !full;
      start_ok = (state == ST_IDLE) && start;
      busy     = (state != ST_IDLE);
      done     = (state == ST_DRAIN_END);
   end

   // Strobe registers: a strobe registered before full rises still lands.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         capture <= 1'b0;
         op      <= OP_NOP;
         issued  <= '0;
      end else begin
         capture <= pop;
         op      <= pop ? head : OP_NOP;
         if (start_ok)  issued <= '0;
         else if (pop)  issued <= issued + CW'(1);
      end
   end

endmodule

// File: tb/tb_capt_issuer.sv
// tb/tb_capt_issuer.sv - table-driven self-checking bench for capt_issuer
module tb_capt_issuer;

   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_op = 2'b00;
   logic       start = 1'b0;
   logic       full  = 1'b0;
   logic [1:0] op;
   logic       capture;
   logic       q_full;
   logic       q_empty;
   logic       busy;
   logic       done;
   logic [7:0] issued;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       we;
      logic [1:0] wo;
      logic       st;
      logic       fu;
      logic       cap;
      logic [1:0] eop;
      logic       bsy;
      logic       dn;
      logic       qe;
      logic       qf;
      logic [7:0] iss;
   } vec_t;

   vec_t tv[$];

   capt_issuer #(.DEPTH(8), .AW(3), .CW(8)) dut (
      .clock   (clock),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_op   (wr_op),
      .start   (start),
      .full    (full),
      .op      (op),
      .capture (capture),
      .q_full  (q_full),
      .q_empty (q_empty),
      .busy    (busy),
      .done    (done),
      .issued  (issued)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic add(input logic we, input logic [1:0] wo, input logic st, input logic fu,
                      input logic cap, input logic [1:0] eop, input logic bsy, input logic dn,
                      input logic qe, input logic qf, input logic [7:0] iss);
      vec_t v;
      v.we = we; v.wo = wo; v.st = st; v.fu = fu;
      v.cap = cap; v.eop = eop; v.bsy = bsy; v.dn = dn; v.qe = qe; v.qf = qf; v.iss = iss;
      tv.push_back(v);
   endtask

   initial begin
      int strobes;
      logic seen_done;

      // inputs (we,wo,st,fu) | outputs after the edge (cap,op,busy,done,q_empty,q_full,issued)
      // basic drain of 01,10,11,00
      add(Y,2'b01,N,N, N,2'b00,N,N,N,N,8'd0);
      add(Y,2'b10,N,N, N,2'b00,N,N,N,N,8'd0);
      add(Y,2'b11,N,N, N,2'b00,N,N,N,N,8'd0);
      add(Y,2'b00,N,N, N,2'b00,N,N,N,N,8'd0);
      add(N,2'b00,Y,N, N,2'b00,Y,N,N,N,8'd0);
      add(N,2'b00,N,N, Y,2'b01,Y,N,N,N,8'd1);
      add(N,2'b00,N,N, Y,2'b10,Y,N,N,N,8'd2);
      add(N,2'b00,N,N, Y,2'b11,Y,N,N,N,8'd3);
      add(N,2'b00,N,N, Y,2'b00,Y,N,Y,N,8'd4);
      add(N,2'b00,N,N, N,2'b00,Y,Y,Y,N,8'd4);
      add(N,2'b00,N,N, N,2'b00,N,N,Y,N,8'd4);
      // start with an empty queue: issued cleared, done one cycle after ISSUE
      add(N,2'b00,Y,N, N,2'b00,Y,N,Y,N,8'd0);
      add(N,2'b00,N,N, N,2'b00,Y,Y,Y,N,8'd0);
      add(N,2'b00,N,N, N,2'b00,N,N,Y,N,8'd0);
      // full stall for 3 cycles after the first strobe
      add(Y,2'b01,N,N, N,2'b00,N,N,N,N,8'd0);
      add(Y,2'b01,N,N, N,2'b00,N,N,N,N,8'd0);
      add(Y,2'b01,N,N, N,2'b00,N,N,N,N,8'd0);
      add(N,2'b00,Y,N, N,2'b00,Y,N,N,N,8'd0);
      add(N,2'b00,N,N, Y,2'b01,Y,N,N,N,8'd1);
      add(N,2'b00,N,Y, N,2'b00,Y,N,N,N,8'd1);
      add(N,2'b00,N,Y, N,2'b00,Y,N,N,N,8'd1);
      add(N,2'b00,N,Y, N,2'b00,Y,N,N,N,8'd1);
      add(N,2'b00,N,N, Y,2'b01,Y,N,N,N,8'd2);
      add(N,2'b00,N,N, Y,2'b01,Y,N,Y,N,8'd3);
      add(N,2'b00,N,N, N,2'b00,Y,Y,Y,N,8'd3);
      add(N,2'b00,N,N, N,2'b00,N,N,Y,N,8'd3);
      // push during drain and an ignored mid-drain start
      add(Y,2'b10,N,N, N,2'b00,N,N,N,N,8'd3);
      add(Y,2'b01,N,N, N,2'b00,N,N,N,N,8'd3);
      add(N,2'b00,Y,N, N,2'b00,Y,N,N,N,8'd0);
      add(Y,2'b11,N,N, Y,2'b10,Y,N,N,N,8'd1);
      add(N,2'b00,Y,N, Y,2'b01,Y,N,N,N,8'd2);
      add(N,2'b00,N,N, Y,2'b11,Y,N,Y,N,8'd3);
      add(N,2'b00,N,N, N,2'b00,Y,Y,Y,N,8'd3);
      add(N,2'b00,N,N, N,2'b00,N,N,Y,N,8'd3);
      add(N,2'b00,N,N, N,2'b00,N,N,Y,N,8'd3);

      // reset state
      #10;
      check("rst_capture", 32'(capture), 32'd0);
      check("rst_op",      32'(op),      32'd0);
      check("rst_done",    32'(done),    32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_issued",  32'(issued),  32'd0);
      check("rst_q_empty", 32'(q_empty), 32'd1);
      check("rst_q_full",  32'(q_full),  32'd0);
      #2 rst_n = 1'b1;

      foreach (tv[i]) begin
         wr_en = tv[i].we; wr_op = tv[i].wo; start = tv[i].st; full = tv[i].fu;
         step();
         check($sformatf("v%0d_capture", i), 32'(capture), 32'(tv[i].cap));
         check($sformatf("v%0d_op", i),      32'(op),      32'(tv[i].eop));
         check($sformatf("v%0d_busy", i),    32'(busy),    32'(tv[i].bsy));
         check($sformatf("v%0d_done", i),    32'(done),    32'(tv[i].dn));
         check($sformatf("v%0d_q_empty", i), 32'(q_empty), 32'(tv[i].qe));
         check($sformatf("v%0d_q_full", i),  32'(q_full),  32'(tv[i].qf));
         check($sformatf("v%0d_issued", i),  32'(issued),  32'(tv[i].iss));
      end
      wr_en = 1'b0; start = 1'b0; full = 1'b0;

      // overflow: 9 pushes into 8 entries, the 9th is dropped
      for (int k = 1; k <= 9; k++) begin
         wr_en = 1'b1; wr_op = 2'b10;
         step();
         check($sformatf("ovf_q_full_push%0d", k), 32'(q_full), (k >= 8) ? 32'd1 : 32'd0);
      end
      wr_en = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      strobes = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 40 && !seen_done; c++) begin
         step();
         if (capture) begin
            strobes++;
            check("ovf_op", 32'(op), 32'h2);
         end
         if (done) seen_done = 1'b1;
      end
      check("ovf_done_seen", 32'(seen_done), 32'd1);
      check("ovf_strobes",   32'(strobes),   32'd8);
      check("ovf_issued",    32'(issued),    32'd8);
      step();

      // reset mid-drain after 2 of 5 strobes
      for (int k = 0; k < 5; k++) begin
         wr_en = 1'b1; wr_op = 2'b01;
         step();
      end
      wr_en = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("mid_capture_before", 32'(capture), 32'd1);
      check("mid_issued_before",  32'(issued),  32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_capture", 32'(capture), 32'd0);
      check("mid_op",      32'(op),      32'd0);
      check("mid_q_empty", 32'(q_empty), 32'd1);
      check("mid_busy",    32'(busy),    32'd0);
      check("mid_done",    32'(done),    32'd0);
      check("mid_issued",  32'(issued),  32'd0);
      for (int k = 0; k < 2; k++) begin
         step();
         check("mid_hold_done", 32'(done), 32'd0);
      end
      #2 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("post_done",    32'(done),    32'd0);
         check("post_capture", 32'(capture), 32'd0);
         check("post_busy",    32'(busy),    32'd0);
         check("post_q_empty", 32'(q_empty), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/capt_issuer.md
Name: capt_issuer

Overview:
Transmit-side counterpart of the capture counter. It buffers a host-written list of 2-bit ops and, after a start command, issues them one per cycle as {op, capture} strobes to a downstream capture counter. Issuing stalls while the downstream `full` is high. The block counts issued ops and pulses `done` when its queue drains. It sits between the host/control logic and the capture counter in the lab datapath.

Parameters:
DEPTH, 8, number of op entries in the internal queue (power of two, at least 2)
AW, 3, queue address width; must equal log2(DEPTH)
CW, 8, width of the issued-op counter

Ports:
clock  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
wr_en  input  1  host push strobe; `wr_op` is written to the queue when high and `q_full` is low
wr_op  input  2  op value to enqueue
start  input  1  begin draining the queue; ignored unless the FSM is in IDLE
full  input  1  downstream counter full; while high, no new op is issued
op  output  2  op presented downstream; 2'b00 whenever `capture` is low
capture  output  1  one-cycle strobe per issued op
q_full  output  1  queue holds DEPTH entries
q_empty  output  1  queue holds 0 entries
busy  output  1  FSM not in IDLE
done  output  1  one-cycle pulse when a drain completes
issued  output  CW  ops issued since the last start; wraps modulo 2^CW

Behaviour:
- Reset (async assert, sync release):
  - `op`=00, `capture`=0, `done`=0, `issued`=0, `busy`=0.
  - Queue is empty: `q_empty`=1, `q_full`=0.
  - FSM enters IDLE.
  - Reset asserted mid-drain aborts the drain and discards all queued ops.
- Queue: FIFO of DEPTH x 2 bits.
  - `q_full` and `q_empty` are combinational from the occupancy count.
  - A push when `q_full`=1 is dropped. The check uses `q_full` before any same-cycle pop.
  - A push and a pop in the same cycle leave occupancy unchanged.
  - Pushes are accepted in every FSM state.
- FSM states: IDLE, ISSUE, DRAIN_END.
  - IDLE:
    - `start`=1 -> ISSUE; `issued` cleared to 0 on the same edge.
    - `start`=1 with `q_empty`=1 still enters ISSUE; the next edge goes to DRAIN_END, so zero ops are issued.
  - ISSUE, on each edge:
    - If `q_empty`=0 and `full`=0: pop head; next cycle `op`=head and `capture`=1; `issued` increments by 1.
    - If `full`=1: no pop; next cycle `capture`=0 and `op`=00 (stall). Stall length is unbounded.
    - If `q_empty`=1: `capture`<=0 and go to DRAIN_END.
  - DRAIN_END: `done`=1 for exactly this one cycle, then IDLE.
  - `busy`=1 in ISSUE and DRAIN_END.
- Latency:
  - `op` and `capture` are registered.
  - The first strobe appears 2 edges after `start` is sampled: the start edge, then the first issue edge.
  - Back-to-back ops issue on consecutive cycles while `full`=0.
- Full handshake:
  - `full` is sampled at the issue edge.
  - A strobe already registered when `full` rises still lands downstream. This is at most one op beyond full, and the capture counter must tolerate it.
- `start` outside IDLE is ignored and does not restart or clear `issued`.
- Ops pushed during ISSUE before the queue empties are issued in the same drain.
- `issued` holds its value after `done` until the next accepted `start`.

Decomposition:
- Shared package holds:
  - op encodings: OP_NOP=2'b00, OP_INC=2'b01, OP_DEC=2'b10, OP_CLR=2'b11 (shared with the capture counter);
  - FSM state typedef/localparams.
- Natural sub-module: `op_fifo` (parameterized DEPTH/AW, 2-bit data). It provides push, pop, head, `q_full` and `q_empty`, plus occupancy.
- FSM, output registers and `issued` counter live in `capt_issuer`.

Test Plan:
- Reset then idle: `rst_n`=0 for 10 ns -> all outputs 0, `q_empty`=1; `start` with an empty queue -> `done` pulses 1 cycle after ISSUE, `issued`=0, no `capture`.
- Basic drain: push 01,10,11,00, pulse `start`, `full`=0 -> `capture`=1 on 4 consecutive cycles with `op`=01,10,11,00; `done` 1 cycle after the last strobe; `issued`=4.
- Full stall: push 01,01,01, start, hold `full`=1 for the 3 cycles after the first strobe is registered -> exactly 1 strobe before the gap, no strobes during the stall, remaining 2 issue after `full` drops; `issued`=3.
- Queue overflow: 9 pushes of 10 with DEPTH=8 while IDLE -> `q_full`=1 after the 8th push, 9th dropped, drain yields exactly 8 strobes.
- Push during drain plus ignored restart: start with 2 ops, push 11 on the first issue cycle, pulse `start` mid-drain -> 3 strobes (last `op`=11), single `done`, `issued`=3 (not cleared).
- Reset mid-drain: assert `rst_n`=0 after 2 of 5 strobes -> `capture`=0 and `op`=00 immediately (async), `q_empty`=1, `busy`=0, no `done` pulse.
